// File: rtl/lock_eval_pkg.sv
// Shared types and constants for the key-lock evaluation harness.
//   state_t     : harness run FSM states
//   LFSR_TAPS   : pattern LFSR feedback mask, polynomial taps 64,63,61,60
//   MISR_TAPS   : signature MISR feedback mask, polynomial taps 32,22,2,1
//   lfsr_next() : one shift-left Fibonacci step of the 64-bit pattern LFSR
package lock_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Tap k of the polynomial maps to bit k-1 of the mask.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Pattern source: Fibonacci shift-left LFSR with loadable seed.
//   clk, rst : clock, synchronous active-high reset
//   load     : load seed (a zero seed loads all-ones so the LFSR never locks up)
//   seed     : seed value
//   step     : advance one position
//   value    : current LFSR state
module lfsr_gen
    import lock_eval_pkg::*;
#(
    parameter int                LFSR_W = 64,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS[LFSR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '1;
        else if (load)
            value <= (seed == '0) ? '1 : seed;
        else if (step)
            value <= {value[LFSR_W-2:0], ^(value & TAPS)};
    end

endmodule

// File: rtl/lock_eval_harness.sv
// Stimulus/compare engine for key-locked combinational benchmarks.
// Drives LFSR patterns and a held key into a locked DUT, compares the DUT
// against an unlocked oracle, counts mismatching patterns and compacts the
// DUT outputs into a MISR signature.
//   clk, rst      : clock, synchronous active-high reset
//   start         : run request, honoured only in IDLE
//   num_patterns  : patterns to apply (sampled on accepted start)
//   seed, key     : LFSR seed and candidate key (sampled on accepted start)
//   pat_out       : registered pattern to DUT and oracle
//   key_out       : registered key to DUT, held for the whole run
//   dut_out       : DUT outputs, combinational from pat_out/key_out
//   oracle_out    : oracle outputs, combinational from pat_out
//   busy, done    : run in progress / one-cycle end-of-run pulse
//   err_count     : mismatching patterns, saturating
//   first_err     : index of first mismatching pattern, all-ones if none
//   signature     : MISR over dut_out of every compared pattern
module lock_eval_harness
    import lock_eval_pkg::*;
#(
    parameter int               N_IN      = 41,
    parameter int               N_OUT     = 32,
    parameter int               N_KEY     = 32,
    parameter int               LFSR_W    = 64,
    parameter int               CNT_W     = 16,
    parameter logic [N_OUT-1:0] MISR_MASK = MISR_TAPS[N_OUT-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [LFSR_W-1:0] seed,
    input  logic [N_KEY-1:0]  key,
    output logic [N_IN-1:0]   pat_out,
    output logic [N_KEY-1:0]  key_out,
    input  logic [N_OUT-1:0]  dut_out,
    input  logic [N_OUT-1:0]  oracle_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err,
    output logic [N_OUT-1:0]  signature
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   cmp_idx;
    logic               vld_q;      // pat_out holds a pattern whose response is compared this edge
    logic [LFSR_W-1:0]  lfsr_val;
    logic               accept;
    logic               mismatch;
    logic [N_OUT-1:0]   sig_nx;
    logic               unused_lfsr_hi;

    assign accept   = (state == IDLE) && start;
    assign mismatch = dut_out != oracle_out;
    assign sig_nx   = {signature[N_OUT-2:0], ^(signature & MISR_MASK)} ^ dut_out;

    // Only the low N_IN bits feed the pattern; the rest lengthen the period.
    assign unused_lfsr_hi = ^lfsr_val[LFSR_W-1:N_IN];

    lfsr_gen #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .seed  (seed),
        .step  (state == RUN),
        .value (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_patterns == '0) ? DONE : RUN;
            RUN:     if (issue_cnt == num_q - ONE) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_out   <= '0;
            key_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            first_err <= '1;
            signature <= '0;
            num_q     <= '0;
            issue_cnt <= '0;
            cmp_idx   <= '0;
            vld_q     <= 1'b0;
        end else begin
            done <= 1'b0;

            // Response to the pattern issued last edge is present now.
            if (vld_q) begin
                cmp_idx   <= cmp_idx + ONE;
                signature <= sig_nx;
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + ONE;
                    if (first_err == '1) first_err <= cmp_idx;
                end
            end

            case (state)
                IDLE: if (start) begin
                    key_out   <= key;
                    num_q     <= num_patterns;
                    err_count <= '0;
                    first_err <= '1;
                    signature <= '0;
                    issue_cnt <= '0;
                    cmp_idx   <= '0;
                    busy      <= 1'b1;
                end
                RUN: begin
                    pat_out   <= lfsr_val[N_IN-1:0];
                    issue_cnt <= issue_cnt + ONE;
                    vld_q     <= 1'b1;
                end
                DRAIN: vld_q <= 1'b0;
                // done and busy are registered, so both change on the edge leaving DONE.
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
